// File: rtl/vc_mem_arb.sv
// vc_mem_arb: arbitrates ifetch, data and debug requesters onto a single-outstanding memory port.
// Build option: define VC_ARB_DEBUG_EN to compile the debug requester in (g_* otherwise ignored).

module vc_mem_arb #(
    parameter int PA = 22,
    parameter int RV = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_req,
    input  logic          d_req,
    input  logic          g_req,
    input  logic [PA-1:0] i_addr,
    input  logic [PA-1:0] d_addr,
    input  logic [PA-1:0] g_addr,
    input  logic          d_we,
    input  logic          g_we,
    input  logic [RV-1:0] d_wdata,
    input  logic [RV-1:0] g_wdata,
    input  logic          d_lock,
    output logic          i_ack,
    output logic          d_ack,
    output logic          g_ack,
    output logic [RV-1:0] rdata,
    output logic          mem_req,
    output logic [PA-1:0] mem_addr,
    output logic          mem_we,
    output logic [RV-1:0] mem_wdata,
    input  logic [RV-1:0] mem_rdata,
    input  logic          mem_done,
    output logic          busy,
    output logic [1:0]    grant
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_I    = 2'b01;
    localparam logic [1:0] GNT_D    = 2'b10;
    localparam logic [1:0] GNT_G    = 2'b11;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [1:0]    r_grant;
    logic [1:0]    w_win;
    logic [PA-1:0] r_addr;
    logic [PA-1:0] w_addr_sel;
    logic          r_we;
    logic          w_we_sel;
    logic [RV-1:0] r_wdata;
    logic [RV-1:0] w_wdata_sel;
    logic [RV-1:0] r_rdata;
    logic          r_lock;
    logic          r_last_d;
    logic          w_g_req;

`ifdef VC_ARB_DEBUG_EN
    assign w_g_req = g_req;
    assign g_ack   = (r_state == DONE) && (r_grant == GNT_G);
`else
    logic w_unused_dbg;
    assign w_unused_dbg = g_req;
    assign w_g_req      = 1'b0;
    assign g_ack        = 1'b0;
`endif

    // A held lock only survives while data keeps both d_req and d_lock high.
    always_comb begin
        w_win = GNT_NONE;
        if (r_lock && d_req && d_lock) begin
            w_win = GNT_D;
        end else if (w_g_req) begin
            w_win = GNT_G;
        end else if (d_req && i_req) begin
            w_win = r_last_d ? GNT_I : GNT_D;
        end else if (d_req) begin
            w_win = GNT_D;
        end else if (i_req) begin
            w_win = GNT_I;
        end
    end

    always_comb begin
        w_addr_sel  = i_addr;
        w_we_sel    = 1'b0;
        w_wdata_sel = '0;
        case (w_win)
            GNT_D: begin
                w_addr_sel  = d_addr;
                w_we_sel    = d_we;
                w_wdata_sel = d_wdata;
            end
            GNT_G: begin
                w_addr_sel  = g_addr;
                w_we_sel    = g_we;
                w_wdata_sel = g_wdata;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_win != GNT_NONE) w_state_nxt = BUSY;
            BUSY:    if (mem_done) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant  <= GNT_NONE;
            r_addr   <= '0;
            r_we     <= 1'b0;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_lock   <= 1'b0;
            r_last_d <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_lock <= (w_win == GNT_D) && d_lock;
                    if (w_win != GNT_NONE) begin
                        r_grant <= w_win;
                        r_addr  <= w_addr_sel;
                        r_we    <= w_we_sel;
                        r_wdata <= w_wdata_sel;
                    end
                    // Debug grants leave the data/ifetch rotation untouched.
                    if (w_win == GNT_D) begin
                        r_last_d <= 1'b1;
                    end else if (w_win == GNT_I) begin
                        r_last_d <= 1'b0;
                    end
                end
                BUSY: begin
                    if (mem_done) r_rdata <= mem_rdata;
                end
                DONE: begin
                    r_grant <= GNT_NONE;
                end
                default: ;
            endcase
        end
    end

    assign mem_req   = (r_state == BUSY);
    assign mem_addr  = r_addr;
    assign mem_we    = r_we && (r_state == BUSY);
    assign mem_wdata = r_wdata;
    assign rdata     = r_rdata;
    assign busy      = (r_state != IDLE);
    assign grant     = r_grant;
    assign i_ack     = (r_state == DONE) && (r_grant == GNT_I);
    assign d_ack     = (r_state == DONE) && (r_grant == GNT_D);

endmodule

// File: tb/tb_vc_mem_arb.sv
// Bench for vc_mem_arb: directed scenarios plus randomized transactions against a
// transaction-level arbitration model.

module tb_vc_mem_arb;

    localparam int PA = 22;
    localparam int RV = 16;
`ifdef VC_ARB_DEBUG_EN
    localparam bit DBG = 1'b1;
`else
    localparam bit DBG = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic          i_req, d_req, g_req;
    logic [PA-1:0] i_addr, d_addr, g_addr;
    logic          d_we, g_we;
    logic [RV-1:0] d_wdata, g_wdata;
    logic          d_lock;
    logic          i_ack, d_ack, g_ack;
    logic [RV-1:0] rdata;
    logic          mem_req;
    logic [PA-1:0] mem_addr;
    logic          mem_we;
    logic [RV-1:0] mem_wdata;
    logic [RV-1:0] mem_rdata;
    logic          mem_done;
    logic          busy;
    logic [1:0]    grant;

    int n_checks = 0;
    int n_errors = 0;

    // Transaction-level model state: lock held by data, and who won the last data/ifetch tie.
    bit m_lock;
    bit m_last_d;

    logic [1:0] tie_order [4];

    vc_mem_arb #(.PA(PA), .RV(RV)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .d_req(d_req), .g_req(g_req),
        .i_addr(i_addr), .d_addr(d_addr), .g_addr(g_addr),
        .d_we(d_we), .g_we(g_we), .d_wdata(d_wdata), .g_wdata(g_wdata),
        .d_lock(d_lock),
        .i_ack(i_ack), .d_ack(d_ack), .g_ack(g_ack),
        .rdata(rdata),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_done(mem_done),
        .busy(busy), .grant(grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] predict();
        if (m_lock && d_req && d_lock) return 2'b10;
        if (DBG && g_req) return 2'b11;
        if (d_req && i_req) return m_last_d ? 2'b01 : 2'b10;
        if (d_req) return 2'b10;
        if (i_req) return 2'b01;
        return 2'b00;
    endfunction

    task automatic model_commit(input logic [1:0] w);
        m_lock = (w == 2'b10) && d_lock;
        if (w == 2'b10) m_last_d = 1'b1;
        if (w == 2'b01) m_last_d = 1'b0;
    endtask

    task automatic set_reqs(input bit ir, input bit dr, input bit gr, input bit dl);
        i_req   = ir;
        d_req   = dr;
        g_req   = gr;
        d_lock  = dl;
        i_addr  = PA'($urandom);
        d_addr  = PA'($urandom);
        g_addr  = PA'($urandom);
        d_we    = 1'($urandom_range(0, 1));
        g_we    = 1'($urandom_range(0, 1));
        d_wdata = RV'($urandom);
        g_wdata = RV'($urandom);
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        mem_done = 1'b0;
        set_reqs(1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst_n    = 1'b1;
        m_lock   = 1'b0;
        m_last_d = 1'b0;
    endtask

    // Entered at a negedge with the DUT idle and request inputs already driven.
    task automatic run_txn(input bit scramble, input int lat, input logic [RV-1:0] rd,
                           output logic [1:0] got);
        logic [1:0]    exp_g;
        logic [PA-1:0] ea;
        logic          ew;
        logic [RV-1:0] ewd;
        exp_g = predict();
        ea    = i_addr;
        ew    = 1'b0;
        ewd   = '0;
        if (exp_g == 2'b10) begin
            ea = d_addr; ew = d_we; ewd = d_wdata;
        end else if (exp_g == 2'b11) begin
            ea = g_addr; ew = g_we; ewd = g_wdata;
        end
        model_commit(exp_g);
        if (exp_g == 2'b00) mem_done = 1'($urandom_range(0, 1));
        @(posedge clk);
        @(negedge clk);
        got = grant;
        if (exp_g == 2'b00) begin
            check("idle_busy", 32'(busy), 32'(1'b0));
            check("idle_mem_req", 32'(mem_req), 32'(1'b0));
            check("idle_grant", 32'(grant), 32'(2'b00));
            mem_done = 1'b0;
            return;
        end
        check("busy_grant", 32'(grant), 32'(exp_g));
        check("busy_flag", 32'(busy), 32'(1'b1));
        check("busy_mem_req", 32'(mem_req), 32'(1'b1));
        check("busy_mem_addr", 32'(mem_addr), 32'(ea));
        check("busy_mem_we", 32'(mem_we), 32'(ew));
        if (exp_g != 2'b01) check("busy_mem_wdata", 32'(mem_wdata), 32'(ewd));
        if (scramble) begin
            set_reqs(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        repeat (lat) begin
            @(posedge clk);
            @(negedge clk);
            check("hold_mem_req", 32'(mem_req), 32'(1'b1));
            check("hold_mem_addr", 32'(mem_addr), 32'(ea));
            check("hold_grant", 32'(grant), 32'(exp_g));
        end
        mem_rdata = rd;
        mem_done  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("done_i_ack", 32'(i_ack), 32'(exp_g == 2'b01));
        check("done_d_ack", 32'(d_ack), 32'(exp_g == 2'b10));
        check("done_g_ack", 32'(g_ack), 32'(exp_g == 2'b11));
        check("done_rdata", 32'(rdata), 32'(rd));
        check("done_mem_req", 32'(mem_req), 32'(1'b0));
        check("done_busy", 32'(busy), 32'(1'b1));
        mem_done  = 1'($urandom_range(0, 1));
        mem_rdata = RV'($urandom);
        @(posedge clk);
        @(negedge clk);
        mem_done = 1'b0;
        check("back_busy", 32'(busy), 32'(1'b0));
        check("back_grant", 32'(grant), 32'(2'b00));
        check("back_acks", 32'({i_ack, d_ack, g_ack}), 32'(3'b000));
    endtask

    initial begin
        logic [1:0] got;
        bit         ir, dr, gr, dl;
        tie_order = '{2'b10, 2'b01, 2'b10, 2'b01};
        rst_n     = 1'b0;
        mem_done  = 1'b0;
        mem_rdata = '0;
        set_reqs(1'b0, 1'b0, 1'b0, 1'b0);

        // Reset state
        @(posedge clk);
        @(negedge clk);
        check("rst_mem_req", 32'(mem_req), 32'(1'b0));
        check("rst_busy", 32'(busy), 32'(1'b0));
        check("rst_grant", 32'(grant), 32'(2'b00));
        check("rst_acks", 32'({i_ack, d_ack, g_ack}), 32'(3'b000));
        check("rst_mem_addr", 32'(mem_addr), 32'(0));
        check("rst_mem_wdata", 32'(mem_wdata), 32'(0));
        check("rst_mem_we", 32'(mem_we), 32'(1'b0));
        check("rst_rdata", 32'(rdata), 32'(0));
        rst_n    = 1'b1;
        m_lock   = 1'b0;
        m_last_d = 1'b0;

        // Data-only read straight out of reset
        set_reqs(1'b0, 1'b1, 1'b0, 1'b0);
        d_addr = 22'h12345;
        d_we   = 1'b0;
        run_txn(1'b0, 0, 16'hBEEF, got);
        check("dread_grant", 32'(got), 32'(2'b10));

        // Continuous data/ifetch tie from reset
        do_reset();
        set_reqs(1'b1, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            run_txn(1'b0, k % 2, RV'($urandom), got);
            check("tie_order", 32'(got), 32'(tie_order[k]));
        end

        // Lock held across back-to-back data transactions
        do_reset();
        set_reqs(1'b0, 1'b1, 1'b0, 1'b1);
        run_txn(1'b0, 1, RV'($urandom), got);
        check("lock_acquire", 32'(got), 32'(2'b10));
        for (int k = 0; k < 3; k++) begin
            set_reqs(1'b1, 1'b1, 1'b1, 1'b1);
            run_txn(1'b0, k, RV'($urandom), got);
            check("lock_hold", 32'(got), 32'(2'b10));
        end
        set_reqs(1'b1, 1'b1, 1'b1, 1'b0);
        run_txn(1'b0, 0, RV'($urandom), got);
        check("lock_release", 32'(got), 32'(DBG ? 2'b11 : 2'b01));

        // Asynchronous reset while a transaction is outstanding
        set_reqs(1'b1, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        check("arst_pre_mem_req", 32'(mem_req), 32'(1'b1));
        i_req = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("arst_mem_req", 32'(mem_req), 32'(1'b0));
        check("arst_busy", 32'(busy), 32'(1'b0));
        check("arst_grant", 32'(grant), 32'(2'b00));
        check("arst_mem_addr", 32'(mem_addr), 32'(0));
        @(negedge clk);
        rst_n    = 1'b1;
        m_lock   = 1'b0;
        m_last_d = 1'b0;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            check("arst_no_ack", 32'({i_ack, d_ack, g_ack}), 32'(3'b000));
            check("arst_idle", 32'(busy), 32'(1'b0));
        end

`ifndef VC_ARB_DEBUG_EN
        // Debug requester compiled out
        set_reqs(1'b0, 1'b0, 1'b1, 1'b0);
        g_addr = 22'h3FFFFF;
        repeat (10) begin
            @(posedge clk);
            @(negedge clk);
            check("nodbg_mem_req", 32'(mem_req), 32'(1'b0));
            check("nodbg_g_ack", 32'(g_ack), 32'(1'b0));
        end
        g_req = 1'b0;
`endif

        // Randomized transactions
        dl = 1'b0;
        for (int n = 0; n < 200; n++) begin
            ir = $urandom_range(0, 99) < 60;
            dr = $urandom_range(0, 99) < 65;
            gr = $urandom_range(0, 99) < 30;
            if ($urandom_range(0, 3) == 0) dl = 1'($urandom_range(0, 1));
            set_reqs(ir, dr, gr, dl);
            run_txn(1'($urandom_range(0, 1)), $urandom_range(0, 3), RV'($urandom), got);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
